// File: rtl/recip_nr_hs.sv
// Signed fixed-point reciprocal: leading-one normalisation, elaborated seed LUT,
// NR_ITERS Newton-Raphson steps, saturation. Optional RECIP_NR_ROUND_EN = round half up.
module recip_nr_hs #(
  parameter int W        = 32,
  parameter int F        = 16,
  parameter int LUT_BITS = 4,
  parameter int NR_ITERS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y_out,
  output logic         div_by_zero,
  output logic         overflow
);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_IT_A, S_IT_B, S_DENORM, S_OUT} state_t;

  localparam logic [W-1:0]   MAX_POS  = W'((64'd1 << (W-1)) - 64'd1);
  localparam logic [2*W-1:0] MAX_WIDE = (2*W)'(MAX_POS);
  localparam logic [W:0]     TWO_Q    = (W+1)'(1) << (F+1);
  localparam logic signed [7:0] F_M1  = 8'(F-1);
`ifdef RECIP_NR_ROUND_EN
  localparam logic [2*W-1:0] RND_F    = (2*W)'(1) << (F-1);
`else
  localparam logic [2*W-1:0] RND_F    = '0;
`endif

  function automatic logic [W:0] lut_val(input int unsigned i);
    logic [63:0] num, den;
    num = 64'd1 << (F + LUT_BITS + 2);
    den = (64'd1 << (LUT_BITS + 1)) + 64'(2*i + 1);
    return (W+1)'((2*num + den) / (2*den));
  endfunction

  logic [W:0] lut [2**LUT_BITS];
  for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_lut
    assign lut[g] = lut_val(g);
  end

  state_t              state_q;
  logic                sign_q;
  logic [W-1:0]        x_abs_q, x_norm_q;
  logic signed [7:0]   e_q;
  logic [W:0]          y_q, t_q;
  logic [2:0]          iter_q;

  logic [W-1:0]        x_abs_c, x_norm_c;
  logic [5:0]          msb_c;
  logic signed [7:0]   e_c, neg_e_c, neg_eq_c;
  logic [LUT_BITS-1:0] idx_c;
  logic [2*W-1:0]      prod_a, prod_b, y_wide, r_c, rnd_d;
  logic [W:0]          t_next, y_next, corr;
  logic                sat_c;
  logic [W-1:0]        y_res;

  assign x_abs_c   = x_in[W-1] ? (~x_in + W'(1)) : x_in;
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_OUT);

  // Seed lookup happens in NORM directly from the freshly shifted operand,
  // which keeps the normal-path latency at 3+2*NR_ITERS edges.
  always_comb begin
    msb_c = '0;
    for (int unsigned i = 0; i < W; i++)
      if (x_abs_q[i]) msb_c = i[5:0];
    e_c     = $signed({2'b00, msb_c}) - F_M1;
    neg_e_c = -e_c;
    if (e_c > 0) x_norm_c = x_abs_q >> e_c[5:0];
    else         x_norm_c = x_abs_q << neg_e_c[5:0];
    idx_c = x_norm_c[F-2 -: LUT_BITS];
  end

  always_comb begin
    prod_a = (2*W)'(x_norm_q) * (2*W)'(y_q);
    t_next = (W+1)'((prod_a + RND_F) >> F);
    corr   = TWO_Q - t_q;
    prod_b = (2*W)'(y_q) * (2*W)'(corr);
    y_next = (W+1)'((prod_b + RND_F) >> F);
  end

  always_comb begin
    y_wide   = (2*W)'(y_q);
    neg_eq_c = -e_q;
    rnd_d    = '0;
    if (e_q > 0) begin
`ifdef RECIP_NR_ROUND_EN
      rnd_d = ((2*W)'(1) << e_q[5:0]) >> 1;
`endif
      r_c = (y_wide + rnd_d) >> e_q[5:0];
    end else begin
      r_c = y_wide << neg_eq_c[5:0];
    end
    sat_c = (r_c > MAX_WIDE);
    if (sat_c) r_c = MAX_WIDE;
    y_res = sign_q ? (~r_c[W-1:0] + W'(1)) : r_c[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      y_out       <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      sign_q      <= 1'b0;
      x_abs_q     <= '0;
      x_norm_q    <= '0;
      e_q         <= '0;
      y_q         <= '0;
      t_q         <= '0;
      iter_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          sign_q  <= x_in[W-1];
          x_abs_q <= x_abs_c;
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (x_abs_q == '0) begin
            y_out       <= MAX_POS;
            div_by_zero <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            x_norm_q <= x_norm_c;
            e_q      <= e_c;
            y_q      <= lut[idx_c];
            iter_q   <= '0;
            state_q  <= S_IT_A;
          end
        end
        S_IT_A: begin
          t_q     <= t_next;
          state_q <= S_IT_B;
        end
        S_IT_B: begin
          y_q <= y_next;
          if (iter_q == 3'(NR_ITERS-1)) begin
            state_q <= S_DENORM;
          end else begin
            iter_q  <= iter_q + 3'd1;
            state_q <= S_IT_A;
          end
        end
        S_DENORM: begin
          y_out    <= y_res;
          overflow <= sat_c;
          state_q  <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_nr_hs.sv
// Directed bench for recip_nr_hs (default parameters, truncating build).
module tb_recip_nr_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_out;
  logic        div_by_zero;
  logic        overflow;

  int n_cmp = 0;
  int n_mis = 0;

  recip_nr_hs #(.W(32), .F(16), .LUT_BITS(4), .NR_ITERS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp, input int tol);
    longint d;
    n_cmp++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, got, got, exp, exp, tol);
    end
  endtask

  // Issue one operand; returns edges from accept edge to out_valid (inclusive).
  task automatic issue(input logic [31:0] x, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("in_ready_idle", longint'(in_ready), 1, 0);
    x_in = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic op_check(input string tag, input logic [31:0] x, input longint exp_y, input int tol,
                          input bit exp_dbz, input bit exp_ovf, input int exp_lat);
    int lat;
    issue(x, lat);
    chk({tag, "_lat"}, longint'(lat), longint'(exp_lat), 0);
    chk({tag, "_y"}, longint'($signed(y_out)), exp_y, tol);
    chk({tag, "_dbz"}, longint'(div_by_zero), longint'(exp_dbz), 0);
    chk({tag, "_ovf"}, longint'(overflow), longint'(exp_ovf), 0);
    @(posedge clk); #1;
    chk({tag, "_ov_clr"}, longint'(out_valid), 0, 0);
    chk({tag, "_flags_clr"}, longint'({div_by_zero, overflow}), 0, 0);
    chk({tag, "_y_hold"}, longint'($signed(y_out)), exp_y, tol);
    chk({tag, "_rdy_back"}, longint'(in_ready), 1, 0);
  endtask

  initial begin
    int lat;
    int ov_seen;
    logic [31:0] y_hold;
    rst = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", longint'(in_ready), 0, 0);
    chk("rst_out_valid", longint'(out_valid), 0, 0);
    chk("rst_y", longint'(y_out), 0, 0);
    chk("rst_flags", longint'({div_by_zero, overflow}), 0, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", longint'(in_ready), 1, 0);

    op_check("two",     32'h0002_0000, 32768, 2, 1'b0, 1'b0, 9);
    op_check("neg4",    32'hFFFC_0000, -16384, 2, 1'b0, 1'b0, 9);
    op_check("zero",    32'h0000_0000, 32'sh7FFF_FFFF, 0, 1'b1, 1'b0, 2);
    op_check("tiny",    32'h0000_0001, 32'sh7FFF_FFFF, 0, 1'b0, 1'b1, 9);
    op_check("ntiny",   32'hFFFF_FFFF, -2147483647, 0, 1'b0, 1'b1, 9);
    op_check("minneg",  32'h8000_0000, -2, 0, 1'b0, 1'b0, 9);

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(32'h0003_0000, lat);
    chk("three_lat", longint'(lat), 9, 0);
    chk("three_y", longint'($signed(y_out)), 21845, 2);
    y_hold = y_out;
    x_in = 32'h0000_7000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", longint'(out_valid), 1, 0);
      chk("stall_y", longint'(y_out), longint'(y_hold), 0);
      chk("stall_flags", longint'({div_by_zero, overflow}), 0, 0);
      chk("stall_ready", longint'(in_ready), 0, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", longint'(out_valid), 0, 0);
    chk("stall_rdy_back", longint'(in_ready), 1, 0);

    // Abort with reset while in IT_B.
    x_in = 32'h0005_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_rdy_in_rst", longint'(in_ready), 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_y_cleared", longint'(y_out), 0, 0);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) ov_seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_result", longint'(ov_seen), 0, 0);
    op_check("one", 32'h0001_0000, 65536, 2, 1'b0, 1'b0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
